// File: rtl/bus_arbiter_pkg.sv
// Arbiter types and the round-robin pick helper.
// Encodings come from constants.v.
`include "constants.v"

package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = `ARB_IDLE,
    BUSY = `ARB_BUSY,
    DONE = `ARB_DONE
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT =
    `ARB_TIMEOUT_DEFAULT;

  // 1 selects master 1; on a tie the master
  // that was not granted last wins.
  function automatic logic rr_pick(
    input logic r0,
    input logic r1,
    input logic last
  );
    logic sel;
    sel = 1'b0;
    unique case (1'b1)
      r0 & r1:  sel = ~last;
      r1 & ~r0: sel = 1'b1;
      default:  sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Per-master request/ack bundle for the bus arbiter.
// master drives the request, slave returns data and ack.
interface bus_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic                  req;
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;

  modport master (
    output req,
    output read,
    output write,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  read,
    input  write,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );

endinterface

// File: rtl/constants.v
// Shared bus constants: I/O widths, arbiter FSM encodings, default timeout.
// Included by the arbiter package and top; guarded against re-inclusion.
`ifndef BUS_ARB_CONSTANTS_V
`define BUS_ARB_CONSTANTS_V

`define IO_ADDR_WIDTH 16
`define IO_DATA_WIDTH 32

`define ARB_IDLE 2'd0
`define ARB_BUSY 2'd1
`define ARB_DONE 2'd2

`define ARB_TIMEOUT_DEFAULT 16

`endif

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto a shared tri-state bus.
// Define BUS_ARB_TIMEOUT_EN to abort stalled transfers with err.
`include "constants.v"

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = `IO_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `IO_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = `ARB_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_read,
  output logic                  bus_write,
  input  logic                  bus_ready,
  output logic                  err
);

  arb_state_t state_q;
  arb_state_t state_d;

  logic grant_q;
  logic last_q;
  logic wr_q;
  logic req0;
  logic req1;
  logic sel;
  logic drive;
  logic timeout;

  assign req0 = m0_req & (m0_read | m0_write);
  assign req1 = m1_req & (m1_read | m1_write);
  assign sel  = rr_pick(req0, req1, last_q);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          to_q;

  assign timeout = ~bus_ready &
    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero outside BUSY, so
  // every transfer starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      to_q <= (state_q == BUSY) & timeout;
      if (state_q == BUSY)
        cnt_q <= cnt_q + CW'(1);
      else
        cnt_q <= '0;
    end
  end
`else
  wire unused_timeout = |TIMEOUT_CYCLES;

  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1)
          state_d = BUSY;
      end
      BUSY: begin
        if (bus_ready | timeout)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_read  = 1'b0;
    bus_write = 1'b0;
    drive     = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    err       = 1'b0;
    bus_addr  = grant_q ? m1_addr : m0_addr;
    unique case (state_q)
      BUSY: begin
        bus_read  = ~wr_q;
        bus_write = wr_q;
        drive     = wr_q;
      end
      DONE: begin
        m0_ack = ~grant_q;
        m1_ack = grant_q;
`ifdef BUS_ARB_TIMEOUT_EN
        err    = to_q;
`endif
      end
      default: ;
    endcase
  end

  assign bus_data = drive
    ? (grant_q ? m1_wdata : m0_wdata)
    : {DATA_WIDTH{1'bz}};

  // Grant and op are latched at grant time so a
  // master dropping req mid-transfer cannot abort it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (state_q == IDLE && state_d == BUSY) begin
        grant_q <= sel;
        wr_q    <= sel ? m1_write : m0_write;
      end
      if (state_q == BUSY && bus_ready && !wr_q) begin
        if (grant_q)
          m1_rdata <= bus_data;
        else
          m0_rdata <= bus_data;
      end
      if (state_q == BUSY && timeout) begin
        if (grant_q)
          m1_rdata <= '0;
        else
          m0_rdata <= '0;
      end
      if (state_q == DONE)
        last_q <= grant_q;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; build with BUS_ARB_TIMEOUT_EN
// defined to exercise the timeout path (TIMEOUT_CYCLES=4).
module tb_bus_arbiter;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TO  = 4;
  localparam int DLY = 3;
`else
  localparam int TO  = 16;
  localparam int DLY = 6;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bus_ready = 1'b0;
  logic tb_drv = 1'b0;
  logic [7:0] tb_val = 8'h00;
  logic [7:0] bus_addr;
  logic bus_read;
  logic bus_write;
  logic err;
  wire  [7:0] bus_data;

  int tests = 0;
  int fails = 0;

  bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) m0 ();
  bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) m1 ();

  assign bus_data = tb_drv ? tb_val : 8'hzz;

  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m0_req(m0.req),
    .m0_read(m0.read),
    .m0_write(m0.write),
    .m0_addr(m0.addr),
    .m0_wdata(m0.wdata),
    .m0_rdata(m0.rdata),
    .m0_ack(m0.ack),
    .m1_req(m1.req),
    .m1_read(m1.read),
    .m1_write(m1.write),
    .m1_addr(m1.addr),
    .m1_wdata(m1.wdata),
    .m1_rdata(m1.rdata),
    .m1_ack(m1.ack),
    .bus_addr(bus_addr),
    .bus_data(bus_data),
    .bus_read(bus_read),
    .bus_write(bus_write),
    .bus_ready(bus_ready),
    .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0.req = 0; m0.read = 0; m0.write = 0;
    m1.req = 0; m1.read = 0; m1.write = 0;
    bus_ready = 0;
    tb_drv = 0;
  endtask

  task automatic apply_reset();
    idle_all();
    m0.addr = 0; m0.wdata = 0;
    m1.addr = 0; m1.wdata = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    m0.req = 1; m0.read = 1; m0.addr = 8'h01;
    tick();
    tick();
    tests++;
    if ({m0.ack, m1.ack, err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ack: got %b want 000",
        {m0.ack, m1.ack, err});
    end
    tests++;
    if ({bus_read, bus_write} !== 2'b00) begin
      fails++;
      $display("FAIL reset_strobe: got %b want 00",
        {bus_read, bus_write});
    end
    tests++;
    if ({m0.rdata, m1.rdata} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_rdata: got %h want 0000",
        {m0.rdata, m1.rdata});
    end
    tests++;
    if (bus_data !== 8'hzz && bus_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %h want z", bus_data);
    end
    idle_all();
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_read();
    m0.req = 1; m0.read = 1; m0.addr = 8'h10;
    tests++;
    if (bus_read !== 1'b0) begin
      fails++;
      $display("FAIL rd_c0_strobe: got %b want 0", bus_read);
    end
    tick();
    tests++;
    if (bus_read !== 1'b1 || bus_addr !== 8'h10) begin
      fails++;
      $display("FAIL rd_c1: got rd=%b addr=%h want 1/10",
        bus_read, bus_addr);
    end
    bus_ready = 1; tb_drv = 1; tb_val = 8'hA5;
    tick();
    tests++;
    if (m0.ack !== 1'b1 || m1.ack !== 1'b0) begin
      fails++;
      $display("FAIL rd_c2_ack: got %b%b want 10",
        m0.ack, m1.ack);
    end
    tests++;
    if (m0.rdata !== 8'hA5 || bus_read !== 1'b0) begin
      fails++;
      $display("FAIL rd_c2: got rdata=%h rd=%b want a5/0",
        m0.rdata, bus_read);
    end
    idle_all();
    tick();
    tests++;
    if (m0.ack !== 1'b0 || m0.rdata !== 8'hA5) begin
      fails++;
      $display("FAIL rd_c3: got ack=%b rdata=%h want 0/a5",
        m0.ack, m0.rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] d;
    logic       a0;
    logic       a1;
    apply_reset();
    m0.addr = 8'h20; m1.addr = 8'h30;
    m0.req = 1; m0.read = 1;
    m1.req = 1; m1.read = 1;
    for (int i = 0; i < 4; i++) begin
      d = 8'h40 + 8'(i);
      tick();
      tests++;
      if (bus_addr !== ((i % 2) == 1 ? 8'h30 : 8'h20)) begin
        fails++;
        $display("FAIL rr_grant%0d: got addr=%h want %h", i,
          bus_addr, (i % 2) == 1 ? 8'h30 : 8'h20);
      end
      bus_ready = 1; tb_drv = 1; tb_val = d;
      tick();
      a0 = (i % 2) == 0;
      a1 = (i % 2) == 1;
      tests++;
      if (m0.ack !== a0 || m1.ack !== a1) begin
        fails++;
        $display("FAIL rr_ack%0d: got %b%b want %b%b", i,
          m0.ack, m1.ack, a0, a1);
      end
      tests++;
      if ((a0 ? m0.rdata : m1.rdata) !== d) begin
        fails++;
        $display("FAIL rr_rdata%0d: got %h want %h", i,
          a0 ? m0.rdata : m1.rdata, d);
      end
      bus_ready = 0; tb_drv = 0;
      if (a0) m0.req = 0; else m1.req = 0;
      tick();
      if (a0) m0.req = 1; else m1.req = 1;
    end
    idle_all();
    tick();
  endtask

  task automatic test_write_delay();
    m1.req = 1; m1.write = 1;
    m1.addr = 8'h55; m1.wdata = 8'h3C;
    tick();
    for (int j = 0; j < DLY; j++) begin
      tests++;
      if (bus_write !== 1'b1 || bus_read !== 1'b0 ||
          bus_data !== 8'h3C || bus_addr !== 8'h55 ||
          m1.ack !== 1'b0) begin
        fails++;
        $display("FAIL wr_busy%0d: got w=%b r=%b d=%h a=%h ack=%b want 1/0/3c/55/0",
          j, bus_write, bus_read, bus_data, bus_addr, m1.ack);
      end
      if (j == DLY - 1) bus_ready = 1;
      tick();
    end
    tests++;
    if (m1.ack !== 1'b1 || m0.ack !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL wr_ack: got m1=%b m0=%b err=%b want 1/0/0",
        m1.ack, m0.ack, err);
    end
    tests++;
    if (bus_write !== 1'b0 ||
        (bus_data !== 8'hzz && bus_data !== 8'h00)) begin
      fails++;
      $display("FAIL wr_release: got w=%b d=%h want 0/z",
        bus_write, bus_data);
    end
    tests++;
    if (m1.rdata !== 8'h43) begin
      fails++;
      $display("FAIL wr_rdata_hold: got %h want 43", m1.rdata);
    end
    idle_all();
    tick();
    tests++;
    if (m1.ack !== 1'b0) begin
      fails++;
      $display("FAIL wr_one_ack: got %b want 0", m1.ack);
    end
  endtask

  task automatic test_read_write_both();
    m0.req = 1; m0.read = 1; m0.write = 1;
    m0.addr = 8'h07; m0.wdata = 8'h77;
    tick();
    tests++;
    if (bus_write !== 1'b1 || bus_read !== 1'b0 ||
        bus_data !== 8'h77) begin
      fails++;
      $display("FAIL rw_as_write: got w=%b r=%b d=%h want 1/0/77",
        bus_write, bus_read, bus_data);
    end
    bus_ready = 1;
    tick();
    tests++;
    if (m0.ack !== 1'b1 || m0.rdata !== 8'h42) begin
      fails++;
      $display("FAIL rw_done: got ack=%b rdata=%h want 1/42",
        m0.ack, m0.rdata);
    end
    idle_all();
    tick();
  endtask

  task automatic test_wait_and_drop();
    m0.req = 1; m0.read = 1; m0.addr = 8'h12;
    tick();
    m0.req = 0; m0.read = 0;
    m1.req = 1; m1.write = 1;
    m1.addr = 8'h70; m1.wdata = 8'h5A;
    tick();
    tests++;
    if (bus_read !== 1'b1 || bus_addr !== 8'h12 ||
        m0.ack !== 1'b0 || m1.ack !== 1'b0) begin
      fails++;
      $display("FAIL drop_busy: got r=%b a=%h ack=%b%b want 1/12/00",
        bus_read, bus_addr, m0.ack, m1.ack);
    end
    bus_ready = 1; tb_drv = 1; tb_val = 8'h3E;
    tick();
    tests++;
    if (m0.ack !== 1'b1 || m1.ack !== 1'b0 ||
        m0.rdata !== 8'h3E) begin
      fails++;
      $display("FAIL drop_ack: got ack=%b%b rdata=%h want 10/3e",
        m0.ack, m1.ack, m0.rdata);
    end
    bus_ready = 0; tb_drv = 0;
    tick();
    tests++;
    if (m0.ack !== 1'b0 || m1.ack !== 1'b0 ||
        bus_write !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: got ack=%b%b w=%b want 00/0",
        m0.ack, m1.ack, bus_write);
    end
    tick();
    tests++;
    if (bus_write !== 1'b1 || bus_addr !== 8'h70 ||
        bus_data !== 8'h5A) begin
      fails++;
      $display("FAIL wait_grant: got w=%b a=%h d=%h want 1/70/5a",
        bus_write, bus_addr, bus_data);
    end
    bus_ready = 1;
    tick();
    tests++;
    if (m1.ack !== 1'b1 || m0.ack !== 1'b0) begin
      fails++;
      $display("FAIL wait_ack: got %b%b want 01",
        m0.ack, m1.ack);
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset_busy();
    m0.req = 1; m0.read = 1; m0.addr = 8'h21;
    tick();
    tests++;
    if (bus_read !== 1'b1) begin
      fails++;
      $display("FAIL rb_busy: got %b want 1", bus_read);
    end
    #2;
    rst_n = 0;
    #1;
    tests++;
    if ({bus_read, bus_write, m0.ack, m1.ack} !== 4'b0000) begin
      fails++;
      $display("FAIL rb_async: got %b want 0000",
        {bus_read, bus_write, m0.ack, m1.ack});
    end
    tests++;
    if ({m0.rdata, m1.rdata} !== 16'h0000) begin
      fails++;
      $display("FAIL rb_rdata: got %h want 0000",
        {m0.rdata, m1.rdata});
    end
    idle_all();
    tick();
    rst_n = 1;
    m1.req = 1; m1.read = 1; m1.addr = 8'h66;
    tick();
    tests++;
    if (bus_read !== 1'b1 || bus_addr !== 8'h66) begin
      fails++;
      $display("FAIL rb_first_arb: got r=%b a=%h want 1/66",
        bus_read, bus_addr);
    end
    bus_ready = 1; tb_drv = 1; tb_val = 8'h99;
    tick();
    tests++;
    if (m1.ack !== 1'b1 || m0.ack !== 1'b0 ||
        m1.rdata !== 8'h99) begin
      fails++;
      $display("FAIL rb_recover: got ack=%b%b rdata=%h want 01/99",
        m0.ack, m1.ack, m1.rdata);
    end
    idle_all();
    tick();
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    m0.req = 1; m0.read = 1; m0.addr = 8'h31;
    tick();
    bus_ready = 1; tb_drv = 1; tb_val = 8'hEE;
    tick();
    tests++;
    if (m0.ack !== 1'b1 || m0.rdata !== 8'hEE) begin
      fails++;
      $display("FAIL to_pre: got ack=%b rdata=%h want 1/ee",
        m0.ack, m0.rdata);
    end
    bus_ready = 0; tb_drv = 0;
    tick();
    tick();
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (bus_read !== 1'b1 || m0.ack !== 1'b0 ||
          err !== 1'b0) begin
        fails++;
        $display("FAIL to_busy%0d: got r=%b ack=%b err=%b want 1/0/0",
          j, bus_read, m0.ack, err);
      end
      tick();
    end
    tests++;
    if (m0.ack !== 1'b1 || err !== 1'b1 ||
        m0.rdata !== 8'h00) begin
      fails++;
      $display("FAIL to_fire: got ack=%b err=%b rdata=%h want 1/1/00",
        m0.ack, err, m0.rdata);
    end
    idle_all();
    tick();
    tests++;
    if (m0.ack !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL to_pulse: got ack=%b err=%b want 0/0",
        m0.ack, err);
    end
  endtask
`else
  task automatic test_timeout();
    int bad;
    bad = 0;
    m0.req = 1; m0.read = 1; m0.addr = 8'h31;
    tick();
    for (int j = 0; j < 100; j++) begin
      if (m0.ack || m1.ack || err || !bus_read)
        bad++;
      tick();
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL no_timeout: got %0d bad cycles want 0", bad);
    end
    apply_reset();
  endtask
`endif

  initial begin
    m0.addr = 0; m0.wdata = 0;
    m1.addr = 0; m1.wdata = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_delay();
    test_read_write_both();
    test_wait_and_drop();
    test_reset_busy();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
